generic_tb_dma_sequencer: RTL and testbench

//  Chunked DMA copy engine for the generic_tb accelerator tile.

---
 rtl/generic_tb_seq_pkg.sv | 27 ++
 rtl/generic_tb_seq_fifo.sv | 61 ++++++
 rtl/generic_tb_dma_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_generic_tb_dma_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/generic_tb_seq_pkg.sv
// Shared types and constants for the generic_tb chunked DMA sequencer.
// Optional feature macro: GENERIC_TB_SEQ_CHECKSUM_EN (consumed by the top).
package generic_tb_seq_pkg;

  localparam int DATA_W      = 32;
  localparam int STATE_W     = 4;
  localparam int CHUNK_CNT_W = 16;

  // Transfer size code for 32-bit words on the DMA ctrl channels.
  localparam logic [2:0] DMA_SIZE_WORD = 3'b010;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 4'd0,
    ST_RD_REQ  = 4'd1,
    ST_RD_DATA = 4'd2,
    ST_WR_REQ  = 4'd3,
    ST_WR_DATA = 4'd4,
    ST_DONE    = 4'd5
  } seq_state_e;

  // Words in the next burst: the full chunk, or whatever is left if smaller.
  function automatic logic [DATA_W-1:0] chunk_len(input logic [DATA_W-1:0] remaining,
                                                  input logic [DATA_W-1:0] chunk_words);
    return (remaining < chunk_words) ? remaining : chunk_words;
  endfunction

endpackage

// File: rtl/generic_tb_seq_fifo.sv
// Synchronous FIFO that stages one read burst before it is written back.
// Push is refused when full and pop when empty, so callers can tie them
// straight to their handshake fire signals.
module generic_tb_seq_fifo
  import generic_tb_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are meaningless while empty so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/generic_tb_dma_sequencer.sv
// Chunked DMA copy engine for the generic_tb accelerator tile.
// Copies conf_info_generic_tb_n words from index reg0 to index reg2 in bursts
// of at most CHUNK_WORDS: read request, read beats into the FIFO, write
// request, write beats from the FIFO, repeat; then a one-cycle acc_done.
// Optional feature macro: GENERIC_TB_SEQ_CHECKSUM_EN turns debug into a
// running mod-2^32 sum of written beats; otherwise debug shows state and the
// number of completed chunks.
//
// Handshakes: every channel transfers on a cycle where valid && ready are
// both high at the rising edge. Once a ctrl valid is raised its index and
// length hold steady until that transfer; data valids/readys follow FIFO
// occupancy and never move a beat without the matching partner signal.
module generic_tb_dma_sequencer
  import generic_tb_seq_pkg::*;
#(
  parameter int CHUNK_WORDS = 16,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] conf_info_reg0,
  input  logic [31:0] conf_info_generic_tb_n,
  input  logic [31:0] conf_info_reg2,
  input  logic        conf_done,
  output logic        dma_read_ctrl_valid,
  input  logic        dma_read_ctrl_ready,
  output logic [31:0] dma_read_ctrl_data_index,
  output logic [31:0] dma_read_ctrl_data_length,
  output logic [2:0]  dma_read_ctrl_data_size,
  input  logic        dma_read_chnl_valid,
  output logic        dma_read_chnl_ready,
  input  logic [31:0] dma_read_chnl_data,
  output logic        dma_write_ctrl_valid,
  input  logic        dma_write_ctrl_ready,
  output logic [31:0] dma_write_ctrl_data_index,
  output logic [31:0] dma_write_ctrl_data_length,
  output logic [2:0]  dma_write_ctrl_data_size,
  output logic        dma_write_chnl_valid,
  input  logic        dma_write_chnl_ready,
  output logic [31:0] dma_write_chnl_data,
  output logic        acc_done,
  output logic [31:0] debug
);

  localparam logic [DATA_W-1:0] CHUNK_W = DATA_W'(CHUNK_WORDS);

  seq_state_e        state;
  seq_state_e        state_next;
  logic [DATA_W-1:0] src_base;
  logic [DATA_W-1:0] dst_base;
  logic [DATA_W-1:0] remaining;
  logic [DATA_W-1:0] offset;
  logic [DATA_W-1:0] beat_cnt;
  logic [DATA_W-1:0] len;
  logic              start;
  logic              rd_ctrl_fire;
  logic              rd_beat_fire;
  logic              wr_ctrl_fire;
  logic              wr_beat_fire;
  logic              last_rd_beat;
  logic              last_wr_beat;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  // remaining only changes at the end of a chunk, so len is constant within one.
  assign len   = chunk_len(remaining, CHUNK_W);
  assign start = (state == ST_IDLE) && conf_done;

  assign dma_read_ctrl_valid        = (state == ST_RD_REQ);
  assign dma_read_ctrl_data_index   = dma_read_ctrl_valid ? (src_base + offset) : '0;
  assign dma_read_ctrl_data_length  = dma_read_ctrl_valid ? len : '0;
  assign dma_read_ctrl_data_size    = DMA_SIZE_WORD;
  assign dma_read_chnl_ready        = (state == ST_RD_DATA) && !fifo_full;

  assign dma_write_ctrl_valid       = (state == ST_WR_REQ);
  assign dma_write_ctrl_data_index  = dma_write_ctrl_valid ? (dst_base + offset) : '0;
  assign dma_write_ctrl_data_length = dma_write_ctrl_valid ? len : '0;
  assign dma_write_ctrl_data_size   = DMA_SIZE_WORD;
  assign dma_write_chnl_valid       = (state == ST_WR_DATA) && !fifo_empty;
  // Stale storage is hidden while the FIFO is empty so reset really zeroes the port.
  assign dma_write_chnl_data        = fifo_empty ? '0 : fifo_head;

  assign rd_ctrl_fire = dma_read_ctrl_valid && dma_read_ctrl_ready;
  assign rd_beat_fire = dma_read_chnl_valid && dma_read_chnl_ready;
  assign wr_ctrl_fire = dma_write_ctrl_valid && dma_write_ctrl_ready;
  assign wr_beat_fire = dma_write_chnl_valid && dma_write_chnl_ready;
  assign last_rd_beat = rd_beat_fire && (beat_cnt == len - 1'b1);
  assign last_wr_beat = wr_beat_fire && (beat_cnt == len - 1'b1);

  generic_tb_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_beat_fire),
    .push_data (dma_read_chnl_data),
    .pop       (wr_beat_fire),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state logic for the request/data phase sequencing.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (conf_done) state_next = (conf_info_generic_tb_n == '0) ? ST_DONE : ST_RD_REQ;
      end
      ST_RD_REQ: begin
        if (rd_ctrl_fire) state_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (last_rd_beat) state_next = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        if (wr_ctrl_fire) state_next = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        if (last_wr_beat) state_next = (remaining == len) ? ST_DONE : ST_RD_REQ;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register, latched configuration, progress counters and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      acc_done  <= 1'b0;
      src_base  <= '0;
      dst_base  <= '0;
      remaining <= '0;
      offset    <= '0;
      beat_cnt  <= '0;
    end else begin
      state    <= state_next;
      acc_done <= (state == ST_DONE);
      if (start) begin
        src_base  <= conf_info_reg0;
        dst_base  <= conf_info_reg2;
        remaining <= conf_info_generic_tb_n;
        offset    <= '0;
        beat_cnt  <= '0;
      end
      if (rd_beat_fire) beat_cnt <= last_rd_beat ? '0 : beat_cnt + 1'b1;
      if (wr_beat_fire) beat_cnt <= last_wr_beat ? '0 : beat_cnt + 1'b1;
      if (last_wr_beat) begin
        remaining <= remaining - len;
        offset    <= offset + len;
      end
    end
  end

`ifdef GENERIC_TB_SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;

  // Running sum of every beat written back, restarted by each accepted conf_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum <= '0;
    end else if (start) begin
      checksum <= '0;
    end else if (wr_beat_fire) begin
      checksum <= checksum + dma_write_chnl_data;
    end
  end

  assign debug = checksum;
`else
  logic [CHUNK_CNT_W-1:0] chunks_done;

  // Count of chunks fully written back in the current copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chunks_done <= '0;
    end else if (start) begin
      chunks_done <= '0;
    end else if (last_wr_beat) begin
      chunks_done <= chunks_done + 1'b1;
    end
  end

  assign debug = {state, 12'd0, chunks_done};
`endif

endmodule

// File: tb/tb_generic_tb_dma_sequencer.sv
// Self-checking bench for generic_tb_dma_sequencer: a table of copy jobs with
// hand-computed chunk counts, plus directed corner sequences (n = 0 timing,
// conf_done re-pulse, reset in the middle of a read burst).
// Honors GENERIC_TB_SEQ_CHECKSUM_EN for the expected debug value.
module tb_generic_tb_dma_sequencer;

  localparam int CHUNK = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] conf_info_reg0;
  logic [31:0] conf_info_generic_tb_n;
  logic [31:0] conf_info_reg2;
  logic        conf_done;
  logic        dma_read_ctrl_valid;
  logic        dma_read_ctrl_ready;
  logic [31:0] dma_read_ctrl_data_index;
  logic [31:0] dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic        dma_read_chnl_valid;
  logic        dma_read_chnl_ready;
  logic [31:0] dma_read_chnl_data;
  logic        dma_write_ctrl_valid;
  logic        dma_write_ctrl_ready;
  logic [31:0] dma_write_ctrl_data_index;
  logic [31:0] dma_write_ctrl_data_length;
  logic [2:0]  dma_write_ctrl_data_size;
  logic        dma_write_chnl_valid;
  logic        dma_write_chnl_ready;
  logic [31:0] dma_write_chnl_data;
  logic        acc_done;
  logic [31:0] debug;

  int checks = 0;
  int errors = 0;

  // Scoreboard state shared between the job tasks and the DMA responder.
  bit          bp = 1'b0;
  logic [31:0] cur_r0 = '0;
  logic [31:0] cur_base = '0;
  logic [31:0] exp_debug = '0;
  logic [31:0] exp_q[$];
  logic [63:0] exp_rd_q[$];
  logic [63:0] exp_wr_q[$];
  logic [31:0] rd_beats_q[$];
  int          done_cnt = 0;
  int          rd_req_cnt = 0;
  int          rd_beats_seen = 0;
  logic [31:0] last_len = '0;

  typedef struct {
    logic [31:0] n;
    logic [31:0] r0;
    logic [31:0] r2;
    logic [31:0] base;
    bit          use_bp;
    int          exp_chunks;
    logic [31:0] exp_last_len;
  } vec_t;

  vec_t vecs[6];

  generic_tb_dma_sequencer #(
    .CHUNK_WORDS (CHUNK),
    .FIFO_DEPTH  (16)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .conf_info_reg0             (conf_info_reg0),
    .conf_info_generic_tb_n     (conf_info_generic_tb_n),
    .conf_info_reg2             (conf_info_reg2),
    .conf_done                  (conf_done),
    .dma_read_ctrl_valid        (dma_read_ctrl_valid),
    .dma_read_ctrl_ready        (dma_read_ctrl_ready),
    .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size    (dma_read_ctrl_data_size),
    .dma_read_chnl_valid        (dma_read_chnl_valid),
    .dma_read_chnl_ready        (dma_read_chnl_ready),
    .dma_read_chnl_data         (dma_read_chnl_data),
    .dma_write_ctrl_valid       (dma_write_ctrl_valid),
    .dma_write_ctrl_ready       (dma_write_ctrl_ready),
    .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
    .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
    .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
    .dma_write_chnl_valid       (dma_write_chnl_valid),
    .dma_write_chnl_ready       (dma_write_chnl_ready),
    .dma_write_chnl_data        (dma_write_chnl_data),
    .acc_done                   (acc_done),
    .debug                      (debug)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // DMA memory responder: drives readys and read beats at negedge, then logs
  // and checks every handshake that the next rising edge will perform.
  initial begin
    bit          rd_wait = 1'b0;
    bit          wr_wait = 1'b0;
    logic [31:0] rd_idx_hold = '0;
    logic [31:0] rd_len_hold = '0;
    logic [31:0] wr_idx_hold = '0;
    logic [31:0] wr_len_hold = '0;
    logic [63:0] e;
    logic [31:0] d;
    dma_read_ctrl_ready  = 1'b0;
    dma_write_ctrl_ready = 1'b0;
    dma_write_chnl_ready = 1'b0;
    dma_read_chnl_valid  = 1'b0;
    dma_read_chnl_data   = '0;
    forever begin
      @(negedge clk);
      dma_read_ctrl_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      dma_write_ctrl_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      dma_write_chnl_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_beats_q.size() != 0 && (!bp || $urandom_range(0, 1) == 1)) begin
        dma_read_chnl_valid = 1'b1;
        dma_read_chnl_data  = rd_beats_q[0];
      end else begin
        dma_read_chnl_valid = 1'b0;
        dma_read_chnl_data  = '0;
      end
      #1;
      if (!rst) begin
        rd_wait = 1'b0;
        wr_wait = 1'b0;
      end else begin
        if (rd_wait) begin
          check("rd_ctrl_hold_valid", 32'(dma_read_ctrl_valid), 32'd1);
          check("rd_ctrl_hold_index", dma_read_ctrl_data_index, rd_idx_hold);
          check("rd_ctrl_hold_length", dma_read_ctrl_data_length, rd_len_hold);
        end
        if (wr_wait) begin
          check("wr_ctrl_hold_valid", 32'(dma_write_ctrl_valid), 32'd1);
          check("wr_ctrl_hold_index", dma_write_ctrl_data_index, wr_idx_hold);
          check("wr_ctrl_hold_length", dma_write_ctrl_data_length, wr_len_hold);
        end
        if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
          rd_req_cnt++;
          last_len = dma_read_ctrl_data_length;
          check("rd_req_size", 32'(dma_read_ctrl_data_size), 32'd2);
          if (exp_rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_req_unexpected: got index 0x%08h length %0d, expected no request",
                     dma_read_ctrl_data_index, dma_read_ctrl_data_length);
          end else begin
            e = exp_rd_q.pop_front();
            check("rd_req_index", dma_read_ctrl_data_index, e[63:32]);
            check("rd_req_length", dma_read_ctrl_data_length, e[31:0]);
          end
          for (int j = 0; j < 64 && 32'(j) < dma_read_ctrl_data_length; j++)
            rd_beats_q.push_back(cur_base + (dma_read_ctrl_data_index + 32'(j) - cur_r0));
        end
        rd_wait     = dma_read_ctrl_valid && !dma_read_ctrl_ready;
        rd_idx_hold = dma_read_ctrl_data_index;
        rd_len_hold = dma_read_ctrl_data_length;
        if (dma_read_chnl_valid && dma_read_chnl_ready) begin
          void'(rd_beats_q.pop_front());
          rd_beats_seen++;
        end
        if (dma_write_ctrl_valid && dma_write_ctrl_ready) begin
          check("wr_req_size", 32'(dma_write_ctrl_data_size), 32'd2);
          if (exp_wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_req_unexpected: got index 0x%08h length %0d, expected no request",
                     dma_write_ctrl_data_index, dma_write_ctrl_data_length);
          end else begin
            e = exp_wr_q.pop_front();
            check("wr_req_index", dma_write_ctrl_data_index, e[63:32]);
            check("wr_req_length", dma_write_ctrl_data_length, e[31:0]);
          end
        end
        wr_wait     = dma_write_ctrl_valid && !dma_write_ctrl_ready;
        wr_idx_hold = dma_write_ctrl_data_index;
        wr_len_hold = dma_write_ctrl_data_length;
        if (dma_write_chnl_valid && dma_write_chnl_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_beat_extra: got 0x%08h, expected no beat", dma_write_chnl_data);
          end else begin
            d = exp_q.pop_front();
            check("wr_beat_data", dma_write_chnl_data, d);
          end
        end
        if (acc_done) begin
          done_cnt++;
          check("debug_at_done", debug, exp_debug);
        end
      end
    end
  end

  // Builds the expected requests/beats for one job and pulses conf_done.
  task automatic start_copy(input logic [31:0] n, input logic [31:0] r0, input logic [31:0] r2,
                            input bit use_bp, input logic [31:0] base);
    logic [31:0] rem;
    logic [31:0] off;
    logic [31:0] l;
    logic [31:0] sum;
    int          chunks;
    bp       = use_bp;
    cur_r0   = r0;
    cur_base = base;
    exp_q.delete();
    exp_rd_q.delete();
    exp_wr_q.delete();
    rem    = n;
    off    = '0;
    sum    = '0;
    chunks = 0;
    while (rem != 0) begin
      l = (rem < 32'(CHUNK)) ? rem : 32'(CHUNK);
      exp_rd_q.push_back({r0 + off, l});
      exp_wr_q.push_back({r2 + off, l});
      rem = rem - l;
      off = off + l;
      chunks++;
    end
    for (int k = 0; k < 64 && 32'(k) < n; k++) begin
      exp_q.push_back(base + 32'(k));
      sum = sum + base + 32'(k);
    end
`ifdef GENERIC_TB_SEQ_CHECKSUM_EN
    exp_debug = sum;
`else
    exp_debug = {16'd0, 16'(chunks)};
`endif
    done_cnt      = 0;
    rd_req_cnt    = 0;
    rd_beats_seen = 0;
    last_len      = '0;
    @(negedge clk);
    conf_info_reg0         = r0;
    conf_info_generic_tb_n = n;
    conf_info_reg2         = r2;
    conf_done              = 1'b1;
    @(negedge clk);
    conf_done = 1'b0;
  endtask

  // Waits (bounded) for completion, then checks pulse count and leftovers.
  task automatic finish_copy(input string tag, input int exp_chunks, input logic [31:0] exp_last);
    int cyc;
    cyc = 0;
    while (done_cnt == 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: got no acc_done in %0d cycles, expected one", tag, cyc);
    end
    repeat (6) @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_rd_requests"}, 32'(rd_req_cnt), 32'(exp_chunks));
    if (exp_chunks > 0) check({tag, "_last_len"}, last_len, exp_last);
    check({tag, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_rd_req_left"}, 32'(exp_rd_q.size()), 32'd0);
    check({tag, "_wr_req_left"}, 32'(exp_wr_q.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    rst                    = 1'b0;
    conf_info_reg0         = '0;
    conf_info_generic_tb_n = '0;
    conf_info_reg2         = '0;
    conf_done              = 1'b0;

    // Reset state.
    #1;
    check("rst_rd_ctrl_valid", 32'(dma_read_ctrl_valid), 32'd0);
    check("rst_rd_chnl_ready", 32'(dma_read_chnl_ready), 32'd0);
    check("rst_wr_ctrl_valid", 32'(dma_write_ctrl_valid), 32'd0);
    check("rst_wr_chnl_valid", 32'(dma_write_chnl_valid), 32'd0);
    check("rst_acc_done", 32'(acc_done), 32'd0);
    check("rst_debug", debug, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    //               n       reg0          reg2          base           bp    chunks last
    vecs[0] = '{32'd40, 32'h0000_0100, 32'h0000_0800, 32'h0000_1000, 1'b0, 3, 32'd8};
    vecs[1] = '{32'd8,  32'h0000_0000, 32'h0000_0040, 32'h0000_0001, 1'b0, 1, 32'd8};
    vecs[2] = '{32'd16, 32'h0000_0200, 32'h0000_0300, 32'hA000_0000, 1'b1, 1, 32'd16};
    vecs[3] = '{32'd1,  32'h0000_0007, 32'h0000_0009, 32'h0000_0055, 1'b1, 1, 32'd1};
    vecs[4] = '{32'd20, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hC0DE_0000, 1'b1, 2, 32'd4};
    vecs[5] = '{32'd33, 32'h0000_0010, 32'h0000_1000, 32'h0000_0003, 1'b1, 3, 32'd1};

    for (int i = 0; i < 6; i++) begin
      start_copy(vecs[i].n, vecs[i].r0, vecs[i].r2, vecs[i].use_bp, vecs[i].base);
      finish_copy($sformatf("vec%0d", i), vecs[i].exp_chunks, vecs[i].exp_last_len);
    end

`ifdef GENERIC_TB_SEQ_CHECKSUM_EN
    // Data 1..8 copied above in vec1; repeat it alone to pin the 36 result.
    start_copy(32'd8, 32'h0, 32'h40, 1'b0, 32'd1);
    check("cksum_model_36", exp_debug, 32'd36);
    finish_copy("cksum", 1, 32'd8);
`endif

    // n = 0: no traffic, acc_done two edges after conf_done is sampled.
    start_copy(32'd0, 32'h40, 32'h80, 1'b0, 32'd0);
    #2;
    check("n0_acc_done_e1", 32'(acc_done), 32'd0);
    check("n0_rd_ctrl_valid", 32'(dma_read_ctrl_valid), 32'd0);
`ifndef GENERIC_TB_SEQ_CHECKSUM_EN
    check("n0_state_done", 32'(debug[31:28]), 32'd5);
`endif
    @(negedge clk);
    #2;
    check("n0_acc_done_e2", 32'(acc_done), 32'd1);
    check("n0_wr_ctrl_valid", 32'(dma_write_ctrl_valid), 32'd0);
    @(negedge clk);
    #2;
    check("n0_acc_done_e3", 32'(acc_done), 32'd0);
    finish_copy("n0", 0, 32'd0);

    // conf_done re-pulsed during WR_DATA with different conf words is ignored.
    start_copy(32'd24, 32'h300, 32'h900, 1'b0, 32'h7700);
    #2;
    check("lat_rd_ctrl_valid", 32'(dma_read_ctrl_valid), 32'd1);
    check("lat_rd_ctrl_index", dma_read_ctrl_data_index, 32'h300);
    check("lat_rd_ctrl_length", dma_read_ctrl_data_length, 32'd16);
    cyc = 0;
    while (!dma_write_chnl_valid && cyc < 200) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    check("repulse_reached_wr_data", 32'(dma_write_chnl_valid), 32'd1);
    @(negedge clk);
    conf_info_reg0         = 32'h5000;
    conf_info_generic_tb_n = 32'd5;
    conf_info_reg2         = 32'h6000;
    conf_done              = 1'b1;
    @(negedge clk);
    conf_done = 1'b0;
    finish_copy("repulse", 2, 32'd8);

    // Asynchronous reset in the middle of a read burst, then a clean rerun.
    start_copy(32'd40, 32'h100, 32'h800, 1'b0, 32'h1000);
    cyc = 0;
    while (rd_beats_seen < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reached_rd_data", 32'(rd_beats_seen >= 5), 32'd1);
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_rd_ctrl_valid", 32'(dma_read_ctrl_valid), 32'd0);
    check("midrst_rd_ctrl_index", dma_read_ctrl_data_index, 32'd0);
    check("midrst_rd_ctrl_length", dma_read_ctrl_data_length, 32'd0);
    check("midrst_rd_chnl_ready", 32'(dma_read_chnl_ready), 32'd0);
    check("midrst_wr_ctrl_valid", 32'(dma_write_ctrl_valid), 32'd0);
    check("midrst_wr_ctrl_index", dma_write_ctrl_data_index, 32'd0);
    check("midrst_wr_chnl_valid", 32'(dma_write_chnl_valid), 32'd0);
    check("midrst_wr_chnl_data", dma_write_chnl_data, 32'd0);
    check("midrst_acc_done", 32'(acc_done), 32'd0);
    check("midrst_debug", debug, 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_rd_q.delete();
    exp_wr_q.delete();
    rd_beats_q.delete();
    @(negedge clk);
    #3;
    rst = 1'b1;
    start_copy(vecs[0].n, vecs[0].r0, vecs[0].r2, 1'b1, vecs[0].base);
    finish_copy("after_rst", vecs[0].exp_chunks, vecs[0].exp_last_len);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
